// File: rtl/kyber_bus_pkg.sv
// Shared types and register map for the Kyber accelerator bus initiator.
package kyber_bus_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_RSVD  = 2'd3
  } bus_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GAP   = 3'd2,
    ST_CHECK = 3'd3,
    ST_RESP  = 3'd4
  } master_state_e;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_entry_t;

  localparam int unsigned RSP_W = 33;

  localparam logic [31:0] ADDR_STATUS = 32'h0000_0000;
  localparam logic [31:0] ADDR_CTRL   = 32'h0000_0004;
  localparam logic [31:0] ADDR_RATE   = 32'h0000_0010;
  localparam logic [31:0] ADDR_DATA   = 32'h0000_0014;
  localparam logic [31:0] ADDR_CMD    = 32'h0000_0020;
  localparam logic [31:0] MEM_BASE    = 32'h0000_1000;

endpackage

// File: rtl/kyber_rsp_fifo.sv
// Show-ahead synchronous response FIFO; DEPTH must be a power of two.
module kyber_rsp_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/kyber_bus_master.sv
// Command-driven bus initiator: one bus transaction sequence and one queued
// response per WRITE/READ/POLL command.
module kyber_bus_master
  import kyber_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned POLL_MAX       = 4096,
  parameter int unsigned RSP_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        bus_enable,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AT_W = $clog2(POLL_MAX + 1);

  master_state_e   state, state_n;
  bus_op_e         op_q, op_n;
  logic [31:0]     data_q, data_n, mask_q, mask_n;
  logic [31:0]     rdata_q, rdata_n, rsp_data_q, rsp_data_n;
  logic            err_q, err_n;
  logic [WD_W-1:0] wd_cnt, wd_n;
  logic [AT_W-1:0] attempts, att_n;
  logic            cmd_ready_n, en_n, wr_n;
  logic [31:0]     addr_n, wdata_n;
  logic            push, fifo_full, fifo_empty;
  rsp_entry_t      push_entry, head_entry;

  assign push_entry = '{err: err_q, data: rsp_data_q};
  assign rsp_data   = head_entry.data;
  assign rsp_err    = head_entry.err;
  assign rsp_valid  = !fifo_empty;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    op_n       = op_q;
    data_n     = data_q;
    mask_n     = mask_q;
    rdata_n    = rdata_q;
    rsp_data_n = rsp_data_q;
    err_n      = err_q;
    wd_n       = wd_cnt;
    att_n      = attempts;
    en_n       = bus_enable;
    wr_n       = bus_write;
    addr_n     = bus_addr;
    wdata_n    = bus_wdata;
    push       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_n       = bus_op_e'(cmd_op);
          addr_n     = cmd_addr;
          data_n     = cmd_data;
          mask_n     = cmd_mask;
          wdata_n    = cmd_data;
          rsp_data_n = '0;
          err_n      = 1'b0;
          if (bus_op_e'(cmd_op) == OP_RSVD) begin
            err_n   = 1'b1;
            att_n   = '0;
            state_n = ST_RESP;
          end else begin
            en_n    = 1'b1;
            wr_n    = (bus_op_e'(cmd_op) == OP_WRITE);
            wd_n    = '0;
            att_n   = AT_W'(1);
            state_n = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // Completion wins over a watchdog expiring on the same edge.
        if (bus_ready) begin
          rdata_n = bus_rdata;
          en_n    = 1'b0;
          wr_n    = 1'b0;
          state_n = ST_GAP;
        end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          wd_n    = WD_W'(TIMEOUT_CYCLES);
          en_n    = 1'b0;
          wr_n    = 1'b0;
          err_n   = 1'b1;
          state_n = ST_GAP;
        end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
          wd_n = wd_cnt + WD_W'(1);
        end
      end
      ST_GAP: begin
        if (err_q || op_q != OP_POLL) begin
          rsp_data_n = (err_q || op_q == OP_WRITE) ? 32'd0 : rdata_q;
          state_n    = ST_RESP;
        end else begin
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        rsp_data_n = rdata_q;
        if ((rdata_q & mask_q) == (data_q & mask_q)) begin
          state_n = ST_RESP;
        end else if (attempts == AT_W'(POLL_MAX)) begin
          err_n   = 1'b1;
          state_n = ST_RESP;
        end else begin
          att_n   = attempts + AT_W'(1);
          en_n    = 1'b1;
          wr_n    = 1'b0;
          wd_n    = '0;
          state_n = ST_ISSUE;
        end
      end
      ST_RESP: begin
        if (!fifo_full) begin
          push    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: begin
        en_n    = 1'b0;
        wr_n    = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
    cmd_ready_n = (state_n == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= OP_WRITE;
      data_q     <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      wd_cnt     <= '0;
      attempts   <= '0;
      cmd_ready  <= 1'b0;
      bus_enable <= 1'b0;
      bus_write  <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      state      <= state_n;
      op_q       <= op_n;
      data_q     <= data_n;
      mask_q     <= mask_n;
      rdata_q    <= rdata_n;
      rsp_data_q <= rsp_data_n;
      err_q      <= err_n;
      wd_cnt     <= wd_n;
      attempts   <= att_n;
      cmd_ready  <= cmd_ready_n;
      bus_enable <= en_n;
      bus_write  <= wr_n;
      bus_addr   <= addr_n;
      bus_wdata  <= wdata_n;
    end
  end

  kyber_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (rsp_ready),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_kyber_bus_master.sv
// Bench for kyber_bus_master: directed table, backpressure/reset sequences,
// and random commands against a transaction-level reference model.
module tb_kyber_bus_master;
  import kyber_bus_pkg::*;

  localparam int TMO = 16, PMAX = 8, DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_addr = '0, cmd_data = '0, cmd_mask = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [31:0] rsp_data;
  logic        bus_enable, bus_write, bus_ready = 1'b0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;

  kyber_bus_master #(.TIMEOUT_CYCLES(TMO), .POLL_MAX(PMAX), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .bus_enable(bus_enable), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  typedef struct { int en; logic [31:0] addr; logic wr; logic [31:0] wdata; } tx_t;
  typedef struct {
    logic [1:0] op; logic [31:0] addr, data, mask; int lat;
    logic [31:0] rd0, rd1, rd2, rd_rest;
    logic exp_err; logic [31:0] exp_data; int exp_tx, exp_en, exp_lat;
  } vec_t;

  tx_t         tx_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] pvals [PMAX];
  int          lat_all = 0, en_cnt = 0, stab_err = 0;
  tx_t         cur;
  int          n_chk = 0, n_pass = 0;
  vec_t        vecs [11];

  function automatic logic [31:0] rd_default(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_1234;
  endfunction

  // Responder: asserts ready on enable cycle lat_all+1 (never if negative).
  always @(negedge clk) begin
    if (!rst_n) begin
      en_cnt = 0; bus_ready = 1'b0; bus_rdata = '0;
    end else if (bus_enable) begin
      if (en_cnt == 0) begin
        cur.addr = bus_addr; cur.wr = bus_write; cur.wdata = bus_wdata;
      end else if (bus_addr != cur.addr || bus_write != cur.wr || bus_wdata != cur.wdata) begin
        stab_err++;
      end
      en_cnt++;
      if (lat_all >= 0 && en_cnt == lat_all + 1) begin
        bus_ready = 1'b1;
        bus_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : rd_default(bus_addr);
      end else begin
        bus_ready = 1'b0; bus_rdata = 32'hBAD0_BAD0;
      end
    end else begin
      if (en_cnt != 0) begin cur.en = en_cnt; tx_q.push_back(cur); end
      en_cnt = 0; bus_ready = 1'b0; bus_rdata = '0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] a, d, m, output bit ok);
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (cmd_ready) begin ok = 1'b1; @(posedge clk); #1 cmd_valid = 1'b0; end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic e, output logic [31:0] d, output int w, output bit ok);
    w = 0;
    while (!rsp_valid && w < 500) begin @(negedge clk); w++; end
    ok = rsp_valid; e = rsp_err; d = rsp_data;
    if (ok) begin rsp_ready = 1'b1; @(posedge clk); #1 rsp_ready = 1'b0; @(negedge clk); end
  endtask

  // Reference model: outcome of one command from responder latency and read values.
  function automatic void model(input logic [1:0] op, input logic [31:0] d, m, input int lat,
                                output logic e, output logic [31:0] rd,
                                output int ntx, output int een, output int elat);
    bit tmo = (lat < 0) || (lat >= TMO);
    een = tmo ? TMO : lat + 1;
    e = 1'b0; rd = '0; ntx = 1; elat = een + 2;
    if (op == 2'(OP_RSVD)) begin
      e = 1'b1; ntx = 0; een = 0; elat = 1;
    end else if (tmo) begin
      e = 1'b1;
    end else if (op == 2'(OP_READ)) begin
      rd = pvals[0];
    end else if (op == 2'(OP_POLL)) begin
      e = 1'b1; ntx = PMAX; rd = pvals[PMAX-1];
      for (int i = 0; i < PMAX; i++) begin
        if ((pvals[i] & m) == (d & m)) begin ntx = i + 1; rd = pvals[i]; e = 1'b0; break; end
      end
      elat = ntx * (een + 2) + 1;
    end
  endfunction

  task automatic run_one(input string tag, input logic [1:0] op, input logic [31:0] a, d, m,
                         input int lat, input logic exp_err, input logic [31:0] exp_data,
                         input int exp_tx, input int exp_en, input int exp_lat);
    bit ok; logic e; logic [31:0] rd; int w, bad;
    tx_q.delete(); rd_q.delete();
    for (int i = 0; i < PMAX; i++) rd_q.push_back(pvals[i]);
    lat_all = lat;
    send_cmd(op, a, d, m, ok);
    chk({tag, "_accept"}, 64'(ok), 64'd1);
    get_rsp(e, rd, w, ok);
    chk({tag, "_rsp"}, {31'd0, e, rd}, {31'd0, exp_err, exp_data});
    chk({tag, "_ntx"}, 64'(tx_q.size()), 64'(exp_tx));
    bad = 0;
    foreach (tx_q[i]) begin
      if (tx_q[i].en != exp_en || tx_q[i].addr != a || tx_q[i].wr != (op == 2'(OP_WRITE))) bad++;
      else if (tx_q[i].wr && tx_q[i].wdata != d) bad++;
    end
    chk({tag, "_tx"}, 64'(bad), 64'd0);
    if (exp_lat >= 0) chk({tag, "_lat"}, 64'(w), 64'(exp_lat));
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    bit ok; logic e; logic [31:0] rd; int w, cnt;
    logic [1:0] op; logic [31:0] a, d, m; int lat, r;
    logic ee; logic [31:0] ed; int ntx, een, elat;

    //           op           addr         data          mask   lat  rd0            rd1         rd2   rest   err  data           tx    en  lat
    vecs[0]  = '{2'(OP_WRITE), 32'h10,      32'd21,       32'h0, 0,   32'h0,         32'h0,      32'h0, 32'h0, 1'b0, 32'h0,         1,    1,  3};
    vecs[1]  = '{2'(OP_READ),  32'h1004,    32'h0,        32'h0, 3,   32'hCAFE_0123, 32'h0,      32'h0, 32'h0, 1'b0, 32'hCAFE_0123, 1,    4,  6};
    vecs[2]  = '{2'(OP_POLL),  ADDR_STATUS, 32'h2,        32'h2, 0,   32'h0,         32'h0,      32'h2, 32'h0, 1'b0, 32'h2,         3,    1,  10};
    vecs[3]  = '{2'(OP_WRITE), ADDR_CTRL,   32'h1,        32'h0, -1,  32'h0,         32'h0,      32'h0, 32'h0, 1'b1, 32'h0,         1,    16, 18};
    vecs[4]  = '{2'(OP_READ),  ADDR_DATA,   32'h0,        32'h0, 15,  32'h1111_2222, 32'h0,      32'h0, 32'h0, 1'b0, 32'h1111_2222, 1,    16, 18};
    vecs[5]  = '{2'(OP_READ),  ADDR_RATE,   32'h0,        32'h0, 16,  32'h3333_4444, 32'h0,      32'h0, 32'h0, 1'b1, 32'h0,         1,    16, 18};
    vecs[6]  = '{2'(OP_RSVD),  ADDR_CMD,    32'h55,       32'h0, 0,   32'h0,         32'h0,      32'h0, 32'h0, 1'b1, 32'h0,         0,    0,  1};
    vecs[7]  = '{2'(OP_POLL),  ADDR_STATUS, 32'h0,        32'h1, 1,   32'h1,         32'h1,      32'h1, 32'h3, 1'b1, 32'h3,         PMAX, 2,  33};
    vecs[8]  = '{2'(OP_POLL),  ADDR_CMD,    32'hFFFF,     32'h0, 2,   32'h1234,      32'h0,      32'h0, 32'h0, 1'b0, 32'h1234,      1,    3,  6};
    vecs[9]  = '{2'(OP_POLL),  MEM_BASE,    32'h80,       32'h80, 0,  32'h7F,        32'hFF80,   32'h0, 32'h0, 1'b0, 32'hFF80,      2,    1,  7};
    vecs[10] = '{2'(OP_POLL),  ADDR_STATUS, 32'h1,        32'h1, -1,  32'h1,         32'h1,      32'h1, 32'h1, 1'b1, 32'h0,         1,    16, 18};

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    chk("reset_ctl", {60'd0, cmd_ready, rsp_valid, busy, bus_enable}, 64'd0);
    chk("reset_bus", {bus_write, bus_addr, bus_wdata[30:0]}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      pvals[0] = vecs[k].rd0; pvals[1] = vecs[k].rd1; pvals[2] = vecs[k].rd2;
      for (int i = 3; i < PMAX; i++) pvals[i] = vecs[k].rd_rest;
      run_one($sformatf("vec%0d", k), vecs[k].op, vecs[k].addr, vecs[k].data, vecs[k].mask,
              vecs[k].lat, vecs[k].exp_err, vecs[k].exp_data, vecs[k].exp_tx, vecs[k].exp_en,
              vecs[k].exp_lat);
    end

    // Backpressure: 4 queued responses, 5th held in RESP until a pop.
    lat_all = 0; rd_q.delete();
    for (int k = 0; k < 5; k++) begin
      send_cmd(2'(OP_READ), MEM_BASE + 32'(4 * k), 32'h0, 32'h0, ok);
      chk($sformatf("bp_accept%0d", k), 64'(ok), 64'd1);
    end
    cnt = 0;
    repeat (12) begin @(negedge clk); if (cmd_ready) cnt++; end
    chk("bp_hold_ready", 64'(cnt), 64'd0);
    chk("bp_hold_busy", {62'd0, busy, rsp_valid}, 64'd3);
    get_rsp(e, rd, w, ok);
    chk("bp_pop0", {31'd0, e, rd}, {32'd0, rd_default(MEM_BASE)});
    cnt = 0;
    while (!cmd_ready && cnt < 10) begin @(negedge clk); cnt++; end
    chk("bp_release", 64'(cmd_ready), 64'd1);
    for (int k = 1; k < 5; k++) begin
      get_rsp(e, rd, w, ok);
      chk($sformatf("bp_pop%0d", k), {31'd0, ok, e, rd}, {31'd1, 1'b0, rd_default(MEM_BASE + 32'(4 * k))});
    end

    // Reset mid-ISSUE with a response still queued.
    lat_all = 0;
    send_cmd(2'(OP_WRITE), ADDR_CTRL, 32'h7, 32'h0, ok);
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin @(negedge clk); cnt++; end
    lat_all = -1;
    send_cmd(2'(OP_READ), ADDR_DATA, 32'h0, 32'h0, ok);
    repeat (3) @(negedge clk);
    chk("rst_pre", {62'd0, bus_enable, rsp_valid}, 64'd3);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {61'd0, bus_enable, rsp_valid, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b1; @(posedge clk); #1 rsp_ready = 1'b0; @(negedge clk);
    chk("rst_empty_pop", 64'(rsp_valid), 64'd0);
    pvals[0] = 32'h600D_F00D;
    for (int i = 1; i < PMAX; i++) pvals[i] = 32'h0;
    run_one("rst_read", 2'(OP_READ), ADDR_DATA, 32'h0, 32'h0, 2, 1'b0, 32'h600D_F00D, 1, 3, 5);

    // Random commands against the reference model.
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 7);
      op = (r == 0) ? 2'(OP_RSVD) : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0: a = ADDR_STATUS;
        1: a = ADDR_DATA;
        2: a = ADDR_CMD;
        default: a = MEM_BASE + 32'($urandom_range(0, 255) * 4);
      endcase
      d = $urandom;
      m = ($urandom_range(0, 1) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'($urandom);
      r = $urandom_range(0, 11);
      lat = (r < 9) ? $urandom_range(0, 3) : (r == 9) ? 15 : (r == 10) ? 16 : -1;
      for (int i = 0; i < PMAX; i++)
        pvals[i] = ($urandom_range(0, 3) == 0) ? ((d & m) | (32'($urandom) & ~m)) : 32'($urandom);
      model(op, d, m, lat, ee, ed, ntx, een, elat);
      run_one($sformatf("rnd%0d", n), op, a, d, m, lat, ee, ed, ntx, een, elat);
    end

    chk("addr_wdata_stable", 64'(stab_err), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
